// File: rtl/dff_bank_arb_pkg.sv
// Shared types, default parameters and sizing helpers for the
// dff_bank_arbiter round-robin register-bank write arbiter.
package dff_bank_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_HOLD = 4;

  // Index width that never collapses to zero bits, so a count/index of a
  // single-entry space still has a legal 1-bit vector.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: lowest set request at or above
// ptr wins, otherwise wrap to the lowest set request overall.
module rr_picker
  import dff_bank_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  input  logic [N_REQ-1:0] excl,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);

  logic [N_REQ-1:0] cand;
  logic [N_REQ-1:0] hi_mask;
  logic [N_REQ-1:0] cand_hi;
  logic [N_REQ-1:0] base;

  assign cand = req & ~excl;

  // Thermometer mask of positions at or above ptr; splitting the search into
  // an upper and a wrapped half avoids a variable rotate.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hi_mask
    assign hi_mask[gi] = (IDX_W'(gi) >= ptr);
  end

  assign cand_hi   = cand & hi_mask;
  assign base      = (|cand_hi) ? cand_hi : cand;
  assign winner    = base & (~base + N_REQ'(1));
  assign any_valid = |cand;

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner[i]) begin
        idx = idx | IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin write arbiter that owns a shared DATA_W-bit register and loads
// the grantee's data on every cycle it holds both grant and request.
module dff_bank_arbiter
  import dff_bank_arb_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int IDX_W   = idx_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wdata,
  output logic [N_REQ-1:0]        gnt,
  output logic [IDX_W-1:0]        owner,
  output logic                    busy,
  output logic [DATA_W-1:0]       q
);

  localparam int              HOLD_W   = idx_width(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  arb_state_e        state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [IDX_W-1:0]  owner_reg, owner_next;
  logic [HOLD_W-1:0] hold_cnt_reg, hold_cnt_next;
  logic [N_REQ-1:0]  gnt_reg, gnt_next;
  logic [DATA_W-1:0] q_reg;

  logic [DATA_W-1:0] wdata_lane [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign wdata_lane[gi] = wdata[gi*DATA_W +: DATA_W];
  end

  // While busy the current owner is masked out, so pick_any means
  // "someone else is waiting" and the winner is always a different requester.
  logic [N_REQ-1:0] excl;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;

  assign excl = (state_reg == BUSY) ? gnt_reg : '0;

  rr_picker #(
    .N_REQ(N_REQ)
  ) u_picker (
    .req      (req),
    .ptr      (ptr_reg),
    .excl     (excl),
    .winner   (pick_onehot),
    .idx      (pick_idx),
    .any_valid(pick_any)
  );

  logic take_new;

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    hold_cnt_next = hold_cnt_reg;
    gnt_next      = gnt_reg;
    take_new      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (pick_any) begin
          take_new = 1'b1;
        end
      end
      BUSY: begin
        if (req[owner_reg]) begin
          if (pick_any && (hold_cnt_reg == HOLD_LAST)) begin
            take_new = 1'b1;
          end else if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
          end
        end else if (pick_any) begin
          take_new = 1'b1;
        end else begin
          state_next    = IDLE;
          gnt_next      = '0;
          hold_cnt_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase

    if (take_new) begin
      state_next    = BUSY;
      gnt_next      = pick_onehot;
      owner_next    = pick_idx;
      hold_cnt_next = '0;
      ptr_next      = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      hold_cnt_reg <= '0;
      gnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      hold_cnt_reg <= hold_cnt_next;
      gnt_reg      <= gnt_next;
    end
  end

  // The outgoing owner still writes on a handover edge if its request is high.
  logic wr_en;
  assign wr_en = |(gnt_reg & req);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg <= '0;
    end else if (wr_en) begin
      q_reg <= wdata_lane[owner_reg];
    end
  end

  assign gnt   = gnt_reg;
  assign owner = owner_reg;
  assign busy  = (state_reg == BUSY);
  assign q     = q_reg;

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin write arbiter for a shared DATA_W-bit flip-flop register bank. Up to N_REQ requesters compete for write ownership. The arbiter grants one requester at a time, loads that requester's data into the bank on every granted cycle, and forces rotation after MAX_HOLD consecutive grant cycles when another requester is waiting. It sits between requester logic and the shared register, and it also owns the register storage.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- DATA_W, 8, width of the shared register
- MAX_HOLD, 4, maximum consecutive grant cycles while another requester is waiting (≥1)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous active-low reset; 0 clears all state immediately
- req  in  N_REQ  request per requester; held high while the requester wants to own the register
- wdata  in  N_REQ*DATA_W  write data; requester i occupies bits [i*DATA_W +: DATA_W]
- gnt  out  N_REQ  registered one-hot grant (all zero when idle)
- owner  out  $clog2(N_REQ)  index of the current grantee; valid when busy=1
- busy  out  1  a grant is active
- q  out  DATA_W  shared register contents

## Operation
- States:
  - IDLE: gnt=0, busy=0.
  - BUSY: exactly one gnt bit is high, busy=1.
- Round-robin pick:
  - Search starts at ptr and wraps modulo N_REQ.
  - ptr resets to 0.
  - On every new grant to requester i, ptr becomes (i+1) mod N_REQ.
- IDLE -> BUSY: at an edge where any req is high, grant the RR winner. hold_cnt is set to 0.
- BUSY, req[owner]=1, no other req: keep the grant. hold_cnt increments and saturates at MAX_HOLD-1.
- BUSY, req[owner]=1, others waiting, hold_cnt<MAX_HOLD-1: keep the grant; hold_cnt increments.
- BUSY, req[owner]=1, others waiting, hold_cnt=MAX_HOLD-1: forced rotation. The grant moves to the RR winner among the other requesters (current owner excluded) at the same edge; hold_cnt becomes 0.
- BUSY, req[owner]=0:
  - If any other req is high, the grant moves to the RR winner at the same edge, with no idle cycle.
  - Otherwise go to IDLE.
- Register write: at each edge where gnt[i]=1 and req[i]=1, q <= wdata[i]. The edge that performs a handover or release still writes the outgoing owner's data only if its req is high. Otherwise q holds.
- Reset values: gnt=0, owner=0, busy=0, q=0, ptr=0, hold_cnt=0, state=IDLE.
- Reset mid-operation: all outputs clear asynchronously. After rst deasserts, the first pick starts from requester 0.

## Timing
- Grant latency: req rises before edge t (arbiter idle) -> gnt visible after edge t. The first write occurs at edge t+1 if req is still high.
- Write latency: q reflects wdata one edge after it is sampled with gnt&req.
- Handover is zero-bubble: gnt switches from A to B in one edge and never shows two bits high.
- Maximum wait for a requester holding req high: (N_REQ-1)*MAX_HOLD grant cycles.
- req and wdata must be synchronous to clk. wdata only needs to be stable while gnt is high.

## Structure
- Package dff_bank_arb_pkg:
  - state enum {IDLE, BUSY}
  - default parameter constants
  - helper function for owner index width
- Sub-module rr_picker: combinational round-robin priority encoder.
  - Inputs: req vector, ptr, exclude-mask.
  - Outputs: one-hot winner, index, any_valid.
- Top level holds the FSM, ptr, hold_cnt, and the q register. All flops use async active-low reset on rst.

## Test plan
- Reset: drive rst=0 with random req/wdata -> gnt=0, busy=0, q=0x00. Release reset; req=4'b0100, wdata[2]=0xA5 -> gnt=4'b0100 after 1 edge, q=0xA5 after 2 edges.
- Round robin: req=4'b1111 continuously, MAX_HOLD=4 -> each requester gets 4 grant cycles in order 0,1,2,3,0. q shows each owner's data during its window.
- Solo hold: only req[1]=1 for 20 cycles -> gnt=4'b0010 throughout, no rotation, hold_cnt saturates at 3.
- Early release: owner 0 drops req after 2 cycles while req[3]=1 -> gnt goes 4'b0001 -> 4'b1000 at the same edge. q is unchanged on the release edge.
- Async reset mid-grant: assert rst between edges while busy -> gnt, busy, and q clear before the next edge. The next grant picks the lowest index, starting from 0.
- Simultaneous drop and new request: req[owner] falls while req[2] rises, same cycle, ptr=1 -> grant to 2. No cycle shows gnt=0 or two gnt bits high.
